// File: rtl/hazard_pkg.sv
// Shared types and limits for the load-use hazard / flush controller.
package hazard_pkg;

  localparam int LOAD_LAT_MAX = 8;
  localparam int REM_W        = $clog2(LOAD_LAT_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int NB_CNT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [NB_CNT-1:0] o_cnt
);

  logic [NB_CNT-1:0] cnt_q, cnt_d;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + NB_CNT'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use hazard stall and IF/ID flush controller with saturating debug counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NB_REG   = 5,
  parameter int LOAD_LAT = 1,
  parameter int NB_CNT   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_clr_cnt,
  input  logic [NB_REG-1:0] i_rs_id,
  input  logic [NB_REG-1:0] i_rt_id,
  input  logic              i_use_rs_id,
  input  logic              i_use_rt_id,
  input  logic [NB_REG-1:0] i_rt_ex,
  input  logic              i_mem_read_ex,
  input  logic              i_jump,
  input  logic              i_branch,
  output logic              o_stall,
  output logic              o_flush,
  output logic [NB_CNT-1:0] o_stall_cnt,
  output logic [NB_CNT-1:0] o_flush_cnt
);

  if ((LOAD_LAT < 1) || (LOAD_LAT > LOAD_LAT_MAX)) begin : g_bad_load_lat
    $error("hazard_ctrl: LOAD_LAT=%0d outside 1..%0d", LOAD_LAT, LOAD_LAT_MAX);
  end

  state_e           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             hit;
  logic             stall;

  assign hit = i_mem_read_ex && (i_rt_ex != '0) &&
               ((i_use_rs_id && (i_rs_id == i_rt_ex)) ||
                (i_use_rt_id && (i_rt_id == i_rt_ex)));

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = hit;
        if (hit && i_en && (LOAD_LAT > 1)) begin
          state_d = STALL;
          rem_d   = REM_W'(LOAD_LAT - 1);
        end
      end
      STALL: begin
        // EX holds a bubble now, so the ID inputs no longer reflect the hazard.
        stall = 1'b1;
        if (i_en) begin
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Stall beats flush: a branch in ID may depend on the pending load.
  assign o_stall = stall && !i_rst;
  assign o_flush = (i_jump || i_branch) && !o_stall && !i_rst;

  sat_counter #(.NB_CNT(NB_CNT)) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (i_en && o_stall),
    .i_clr (i_clr_cnt),
    .o_cnt (o_stall_cnt)
  );

  sat_counter #(.NB_CNT(NB_CNT)) u_flush_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (i_en && o_flush),
    .i_clr (i_clr_cnt),
    .o_cnt (o_flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: two hazard_ctrl instances (LOAD_LAT=3/NB_CNT=4 and LOAD_LAT=1/NB_CNT=16).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, clr_cnt;
  logic [4:0] rs_id, rt_id, rt_ex;
  logic       use_rs, use_rt, mem_read, jump, branch;

  logic        stall_a, flush_a, stall_b, flush_b;
  logic [3:0]  scnt_a, fcnt_a;
  logic [15:0] scnt_b, fcnt_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.NB_REG(5), .LOAD_LAT(3), .NB_CNT(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr_cnt(clr_cnt),
    .i_rs_id(rs_id), .i_rt_id(rt_id), .i_use_rs_id(use_rs), .i_use_rt_id(use_rt),
    .i_rt_ex(rt_ex), .i_mem_read_ex(mem_read), .i_jump(jump), .i_branch(branch),
    .o_stall(stall_a), .o_flush(flush_a), .o_stall_cnt(scnt_a), .o_flush_cnt(fcnt_a)
  );

  hazard_ctrl #(.NB_REG(5), .LOAD_LAT(1), .NB_CNT(16)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr_cnt(clr_cnt),
    .i_rs_id(rs_id), .i_rt_id(rt_id), .i_use_rs_id(use_rs), .i_use_rt_id(use_rt),
    .i_rt_ex(rt_ex), .i_mem_read_ex(mem_read), .i_jump(jump), .i_branch(branch),
    .o_stall(stall_b), .o_flush(flush_b), .o_stall_cnt(scnt_b), .o_flush_cnt(fcnt_b)
  );

  // Reference: a hazard opens a window lasting LAT enabled cycles, measured on an
  // enabled-cycle timeline; counters are plain integers clamped at their maximum.
  typedef struct {
    int lat;
    int cmax;
    int ecnt;
    int win_end;
    int scnt;
    int fcnt;
  } mdl_t;

  typedef struct {
    int st[2];
    int fl[2];
    int sc[2];
    int fc[2];
  } exp_t;

  mdl_t m[2];
  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  function automatic bit ref_hit();
    return mem_read && (rt_ex != 0) &&
           ((use_rs && (rs_id == rt_ex)) || (use_rt && (rt_id == rt_ex)));
  endfunction

  // Applies after inputs settle: push expected outputs, then advance the model over the next edge.
  task automatic step();
    exp_t e;
    bit   h;
    #1;
    h = ref_hit();
    for (int k = 0; k < 2; k++) begin
      bit in_win;
      in_win = m[k].ecnt < m[k].win_end;
      e.st[k] = (!rst && (in_win || h)) ? 1 : 0;
      e.fl[k] = (!rst && (jump || branch) && (e.st[k] == 0)) ? 1 : 0;
      e.sc[k] = rst ? 0 : m[k].scnt;
      e.fc[k] = rst ? 0 : m[k].fcnt;
      if (rst) begin
        m[k].ecnt = 0;
        m[k].win_end = 0;
        m[k].scnt = 0;
        m[k].fcnt = 0;
      end else begin
        if (clr_cnt) begin
          m[k].scnt = 0;
          m[k].fcnt = 0;
        end else if (en) begin
          m[k].scnt = (m[k].scnt + e.st[k] > m[k].cmax) ? m[k].cmax : m[k].scnt + e.st[k];
          m[k].fcnt = (m[k].fcnt + e.fl[k] > m[k].cmax) ? m[k].cmax : m[k].fcnt + e.fl[k];
        end
        if (en) begin
          if (!in_win && h) m[k].win_end = m[k].ecnt + m[k].lat;
          m[k].ecnt++;
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b1; clr_cnt = 1'b0;
    rs_id = '0; rt_id = '0; rt_ex = '0;
    use_rs = 1'b0; use_rt = 1'b0; mem_read = 1'b0; jump = 1'b0; branch = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] dst);
    mem_read = 1'b1; rt_ex = dst; rs_id = dst; use_rs = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("a_stall", int'(stall_a), e.st[0]);
      check("a_flush", int'(flush_a), e.fl[0]);
      check("a_stall_cnt", int'(scnt_a), e.sc[0]);
      check("a_flush_cnt", int'(fcnt_a), e.fc[0]);
      check("b_stall", int'(stall_b), e.st[1]);
      check("b_flush", int'(flush_b), e.fl[1]);
      check("b_stall_cnt", int'(scnt_b), e.sc[1]);
      check("b_flush_cnt", int'(fcnt_b), e.fc[1]);
    end
  end

  initial begin
    m[0] = '{lat: 3, cmax: 15, ecnt: 0, win_end: 0, scnt: 0, fcnt: 0};
    m[1] = '{lat: 1, cmax: 65535, ecnt: 0, win_end: 0, scnt: 0, fcnt: 0};
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;
    step();

    // Basic hazard; load indicator drops after the first cycle.
    load_use(5'd5); step();
    idle_inputs(); step(); step(); step();

    // Enable low twice mid-stall stretches the window.
    load_use(5'd5); step();
    idle_inputs(); en = 1'b0; step(); step();
    en = 1'b1; step(); step(); step();

    // Register 0 and unused operand never stall.
    mem_read = 1'b1; rt_ex = 5'd0; rs_id = 5'd0; use_rs = 1'b1; step();
    idle_inputs(); mem_read = 1'b1; rt_ex = 5'd7; rt_id = 5'd7; use_rt = 1'b0; step();

    // Branch during stall is held off, then flushes once the stall ends.
    idle_inputs(); load_use(5'd9); branch = 1'b1; step();
    mem_read = 1'b0; step(); step(); step(); step();
    idle_inputs(); step();

    // Reset in the second stall cycle.
    load_use(5'd4); step();
    idle_inputs(); rst = 1'b1; step();
    rst = 1'b0; step(); step();

    // Continuous hazard drives the narrow counter into saturation, then clear with stall.
    load_use(5'd3);
    repeat (20) step();
    clr_cnt = 1'b1; step();
    clr_cnt = 1'b0; step(); step();
    idle_inputs(); step();

    // Randomized traffic over a small register space to make hits frequent.
    repeat (600) begin
      rst      = ($urandom_range(0, 99) < 2);
      en       = ($urandom_range(0, 99) < 80);
      clr_cnt  = ($urandom_range(0, 99) < 3);
      rs_id    = 5'($urandom_range(0, 3));
      rt_id    = 5'($urandom_range(0, 3));
      rt_ex    = 5'($urandom_range(0, 3));
      use_rs   = 1'($urandom);
      use_rt   = 1'($urandom);
      mem_read = ($urandom_range(0, 99) < 50);
      jump     = ($urandom_range(0, 99) < 15);
      branch   = ($urandom_range(0, 99) < 15);
      step();
    end
    rst = 1'b0;
    idle_inputs();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    #20;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised load-use hazard and control-flush controller for the 5-stage MIPS pipeline, sitting beside the control unit between ID and EX. It detects load-use dependencies, holds PC/IF-ID and bubbles the control unit for a configurable number of cycles to match the data-memory load latency. It issues IF/ID flushes for taken jumps/branches with defined priority against stalls, and keeps saturating stall/flush event counters for the debug unit.

## Interface
Parameters:
- NB_REG, 5, register-address width
- LOAD_LAT, 1, stall cycles per load-use hazard (legal 1..8)
- NB_CNT, 16, width of each event counter

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_en  in  1  pipeline step enable (debug unit); 0 freezes all internal state
- i_clr_cnt  in  1  synchronous clear of both event counters
- i_rs_id  in  NB_REG  rs of instruction in ID
- i_rt_id  in  NB_REG  rt of instruction in ID
- i_use_rs_id  in  1  ID instruction reads rs
- i_use_rt_id  in  1  ID instruction reads rt
- i_rt_ex  in  NB_REG  destination (rt) of instruction in EX
- i_mem_read_ex  in  1  EX instruction is a load
- i_jump  in  1  jump taken in ID
- i_branch  in  1  branch taken in ID
- o_stall  out  1  hold PC and IF/ID, zero control signals into ID/EX
- o_flush  out  1  flush IF/ID
- o_stall_cnt  out  NB_CNT  stall cycles counted
- o_flush_cnt  out  NB_CNT  flushes counted

## Operation
- hit = i_mem_read_ex & (i_rt_ex != 0) & ((i_use_rs_id & i_rs_id == i_rt_ex) | (i_use_rt_id & i_rt_id == i_rt_ex)). Register 0 never causes a hazard. An unused operand never causes a hazard.
- FSM, two states:
  - IDLE: o_stall = hit.
    - If hit & i_en & LOAD_LAT > 1: go to STALL with remaining = LOAD_LAT-1.
  - STALL: o_stall = 1 regardless of inputs, because EX now holds a bubble. This state is unreachable when LOAD_LAT = 1.
    - On each enabled cycle: decrement remaining.
    - When remaining = 1 on an enabled cycle: return to IDLE. A new hit is evaluated in IDLE the next cycle.
- o_flush = (i_jump | i_branch) & ~o_stall.
  - Stall wins: the branch in ID may depend on the pending load, so it is re-evaluated after the stall.
  - No flush is lost; ID holds the branch until the stall ends.
- Event counters, enabled cycles only:
  - o_stall_cnt increments on each cycle with o_stall = 1.
  - o_flush_cnt increments on each cycle with o_flush = 1.
  - Both saturate at 2^NB_CNT-1.
  - i_clr_cnt clears them to 0 and has priority over increment. i_clr_cnt acts even when i_en = 0.
- i_en = 0:
  - FSM state, remaining and counters hold.
  - o_stall and o_flush are still driven combinationally from the current state and inputs.
- i_rst high:
  - State goes to IDLE, remaining to 0, counters to 0.
  - o_stall and o_flush are forced to 0 while reset is asserted.
  - Reset mid-stall aborts the stall immediately.

## Timing
- o_stall and o_flush are combinational from inputs and state: zero-cycle latency, valid before the same rising edge.
- A load in EX at cycle t with a dependent in ID gives o_stall high for cycles t..t+LOAD_LAT-1 (with i_en = 1 throughout) and low at t+LOAD_LAT.
- Cycles with i_en = 0 extend the stall window one-for-one.
- Counter outputs are registered: they reflect events up to the previous edge, i.e. one cycle of latency.
- Reset values: o_stall = 0, o_flush = 0, o_stall_cnt = 0, o_flush_cnt = 0.

## Structure
- Package hazard_pkg holds:
  - the state typedef (IDLE, STALL)
  - LOAD_LAT_MAX = 8
  - the width of remaining, $clog2(LOAD_LAT_MAX+1)
- LOAD_LAT outside 1..8 is rejected by an elaboration-time check.
- One sub-module, sat_counter (NB_CNT wide, with inc and clr inputs), is instantiated twice for the event counters.

## Test plan
- LOAD_LAT=1, load writes rt=5 in EX, ID uses rs=5 -> o_stall high exactly 1 cycle, o_stall_cnt=1 next cycle.
- LOAD_LAT=3, same hazard -> o_stall high 3 consecutive cycles even though i_mem_read_ex drops after cycle 1; i_en low for 2 cycles mid-stall -> stall lasts 5 cycles, o_stall_cnt=3.
- Load to rt=0 with rs_id=0, and load rt=7 with rt_id=7 but i_use_rt_id=0 -> o_stall never asserts.
- i_branch=1 during an active stall -> o_flush=0; i_branch still 1 in the first cycle after the stall -> o_flush=1, o_flush_cnt=1.
- Assert i_rst in the 2nd cycle of a LOAD_LAT=4 stall -> o_stall=0 immediately, state IDLE, counters 0 after release.
- Counters with NB_CNT=4: 20 stall cycles -> o_stall_cnt saturates at 15; i_clr_cnt together with a stall -> reads 0.
